async_fifo_rd_ctrl: RTL
=======================

ASYNC_FIFO_RD_CTRL -- requirements
Module: async_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: FIFO memory address width, depth 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: word width.
REQ-003 SHALL have parameter AEMPTY_THRESH, default 2: almost-empty threshold in words.
REQ-004 SHALL have port rd_clk  input  1  read-domain clock; all state on rising edge.
REQ-005 SHALL have port rd_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wrptr_sync  input  ADDR_WIDTH+1  Gray write pointer already synchronized into rd_clk.
REQ-007 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en.
REQ-008 SHALL have port mem_rd_en  output  1  memory read strobe.
REQ-009 SHALL have port mem_raddr  output  ADDR_WIDTH  memory read address.
REQ-010 SHALL have port rd_ptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer for the write-domain synchronizer.
REQ-011 SHALL have port m_valid  output  1  output word valid.
REQ-012 SHALL have port m_data  output  DATA_WIDTH  output word.
REQ-013 SHALL have port m_ready  input  1  consumer accepts word.
REQ-014 SHALL have port empty  output  1  memory holds no unfetched words.
REQ-015 SHALL have port aempty  output  1  unfetched words <= AEMPTY_THRESH.
REQ-016 SHALL have port rd_level  output  ADDR_WIDTH+1  unfetched word count.

Function
REQ-017 SHALL convert wrptr_sync Gray->binary combinationally (wr_bin).
REQ-018 SHALL hold binary read pointer rd_bin (ADDR_WIDTH+1 bits); mem_raddr = rd_bin[ADDR_WIDTH-1:0]; rd_ptr_gray = registered rd_bin ^ (rd_bin >> 1).
REQ-019 SHALL compute rd_level = (wr_bin - rd_bin) mod 2^(ADDR_WIDTH+1); empty = (rd_level == 0); aempty = (rd_level <= AEMPTY_THRESH).
REQ-020 SHALL contain a 2-entry output buffer (head drives m_data) with occupancy states ZERO, ONE, TWO plus one in-flight bit.
REQ-021 SHALL assert mem_rd_en when !empty and (occupancy + in_flight - pop) < 2, pop = m_valid && m_ready.
REQ-022 SHALL, on a mem_rd_en cycle, increment rd_bin and update rd_ptr_gray on that same edge, and set in_flight for the next cycle.
REQ-023 SHALL capture mem_rdata into the buffer in the cycle after mem_rd_en; FIFO order preserved.
REQ-024 SHALL assert m_valid whenever occupancy > 0; latency from wrptr_sync becoming non-empty (buffer idle) to m_valid = 2 cycles.
REQ-025 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-026 SHALL sustain one word per cycle with m_ready held high and memory non-empty.
REQ-027 SHALL handle simultaneous pop and capture in the same cycle without loss or duplication.
REQ-028 SHALL wrap rd_bin from 2^(ADDR_WIDTH+1)-1 to 0 and mem_raddr from 2^ADDR_WIDTH-1 to 0.
REQ-029 SHALL treat wrptr_sync as monotonically advancing; rd_level > 2^ADDR_WIDTH is out of contract.

Reset
REQ-030 SHALL, on rd_rst_n low, force immediately: rd_bin=0, rd_ptr_gray=0, occupancy ZERO, in_flight=0, m_valid=0, m_data=0, mem_rd_en=0 (registered state).
REQ-031 SHALL discard any in-flight read on reset; that word never appears on m_data.
REQ-032 SHALL present empty=1, aempty=1, rd_level=0 after reset while wrptr_sync=0.

Verification
REQ-033 Reset, wrptr_sync=0 -> empty=1, aempty=1, m_valid=0, mem_rd_en=0, rd_ptr_gray=00000.
REQ-034 wrptr_sync=00001 at cycle N, m_ready=0 -> mem_rd_en=1, mem_raddr=0 at N; rd_ptr_gray=00001 from N+1; m_valid=1 from N+2, held.
REQ-035 wrptr_sync jumps to binary 8 (Gray 01100), m_ready=1 -> 8 consecutive mem_rd_en, 8 consecutive m_valid/m_ready beats, addresses 0..7 in order, then empty=1.
REQ-036 5 words, m_ready=0 -> exactly 2 fetches, rd_level=3, m_data stable; raise m_ready -> remaining 3 delivered in order, no gaps after first.
REQ-037 40 words streamed -> rd_bin wraps 31->0 (Gray 10000->00000), mem_raddr wraps 15->0, 40 words in order, none lost.
REQ-038 Assert rd_rst_n low with buffer TWO and in_flight=1 -> all outputs at reset values next sample; discarded words never appear.

Source files
------------

// File: rtl/async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : async_fifo_rd_ctrl
// Brief   : Read-side controller of an asynchronous FIFO with a 2-entry
//           prefetch buffer presenting a valid/ready stream.
// Revision: 1.0 - initial release
// ============================================================================
module async_fifo_rd_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic [ADDR_WIDTH:0]   wrptr_sync,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam logic [ADDR_WIDTH:0] c_AEMPTY_THRESH = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] c_PTR_ONE       = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        OCC_ZERO = 2'd0,
        OCC_ONE  = 2'd1,
        OCC_TWO  = 2'd2
    } occ_t;

    occ_t                  r_occ;
    logic                  r_in_flight;
    logic                  r_active;
    logic [ADDR_WIDTH:0]   r_rd_bin;
    logic [DATA_WIDTH-1:0] r_tail;

    logic [ADDR_WIDTH:0]   w_wr_bin;
    logic [ADDR_WIDTH:0]   w_rd_bin_nxt;
    logic                  w_pop;
    logic [2:0]            w_committed;
    logic [2:0]            w_budget;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        w_wr_bin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            w_wr_bin[i] = ^(wrptr_sync >> i);
        end
    end

    assign rd_level     = w_wr_bin - r_rd_bin;
    assign empty        = (rd_level == '0);
    assign aempty       = (rd_level <= c_AEMPTY_THRESH);
    assign mem_raddr    = r_rd_bin[ADDR_WIDTH-1:0];
    assign w_rd_bin_nxt = r_rd_bin + c_PTR_ONE;

    // A fetch is allowed only if buffered + in-flight words, after this
    // cycle's pop, still leave a free slot for the returning word.
    assign w_pop       = m_valid && m_ready;
    assign w_committed = {1'b0, r_occ} + {2'b00, r_in_flight};
    assign w_budget    = 3'd2 + {2'b00, w_pop};
    assign mem_rd_en   = r_active && !empty && (w_committed < w_budget);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_active    <= 1'b0;
            r_in_flight <= 1'b0;
            r_rd_bin    <= '0;
            rd_ptr_gray <= '0;
            r_occ       <= OCC_ZERO;
            r_tail      <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
        end else begin
            r_active    <= 1'b1;
            r_in_flight <= mem_rd_en;
            if (mem_rd_en) begin
                r_rd_bin    <= w_rd_bin_nxt;
                rd_ptr_gray <= w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);
            end

            case (r_occ)
                OCC_ZERO: begin
                    if (r_in_flight) begin
                        m_data  <= mem_rdata;
                        m_valid <= 1'b1;
                        r_occ   <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({w_pop, r_in_flight})
                        2'b11: m_data <= mem_rdata;
                        2'b10: begin
                            m_valid <= 1'b0;
                            r_occ   <= OCC_ZERO;
                        end
                        2'b01: begin
                            r_tail <= mem_rdata;
                            r_occ  <= OCC_TWO;
                        end
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    // No fetch is ever outstanding while both slots are full.
                    if (w_pop) begin
                        m_data <= r_tail;
                        if (r_in_flight) begin
                            r_tail <= mem_rdata;
                        end else begin
                            r_occ <= OCC_ONE;
                        end
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    r_occ   <= OCC_ZERO;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
